// File: rtl/writeback_arbiter.sv
// Write-back arbiter: owns the register-bank write port, round-robins ALU vs load-return
// writes (one per cycle), and tracks per-register pending writes for RAW stall detection.
module writeback_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter int NREG   = 2**ADDR_W
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_Stall,
    input  logic              i_AluValid,
    input  logic [ADDR_W-1:0] i_AluAddr,
    input  logic [DATA_W-1:0] i_AluData,
    output logic              o_AluReady,
    input  logic              i_MemValid,
    input  logic [ADDR_W-1:0] i_MemAddr,
    input  logic [DATA_W-1:0] i_MemData,
    output logic              o_MemReady,
    input  logic              i_IssueValid,
    input  logic [ADDR_W-1:0] i_IssueAddr,
    output logic              o_WriteBack,
    output logic [ADDR_W-1:0] o_AddrRegDest,
    output logic [DATA_W-1:0] o_WriteData,
    output logic [NREG-1:0]   o_Pending
);

    typedef enum logic {GRANT_ALU = 1'b0, GRANT_MEM = 1'b1} grant_e;

    grant_e          last_grant;
    logic            transfer;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        o_AluReady = 1'b0;
        o_MemReady = 1'b0;
        if (!i_Stall) begin
            o_AluReady = i_AluValid && (!i_MemValid || last_grant == GRANT_MEM);
            o_MemReady = i_MemValid && (!i_AluValid || last_grant == GRANT_ALU);
        end
    end

    assign transfer = o_AluReady || o_MemReady;

    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (i_IssueValid)
            set_mask[i_IssueAddr] = 1'b1;
        if (o_WriteBack)
            clr_mask[o_AddrRegDest] = 1'b1;
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            last_grant    <= GRANT_ALU;
            o_WriteBack   <= 1'b0;
            o_AddrRegDest <= '0;
            o_WriteData   <= '0;
        end else begin
            o_WriteBack <= transfer;
            if (o_MemReady) begin
                last_grant    <= GRANT_MEM;
                o_AddrRegDest <= i_MemAddr;
                o_WriteData   <= i_MemData;
            end else if (o_AluReady) begin
                last_grant    <= GRANT_ALU;
                o_AddrRegDest <= i_AluAddr;
                o_WriteData   <= i_AluData;
            end
        end
    end

    // Set after clear so a fresh issue to a register being written stays outstanding.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST)
            o_Pending <= '0;
        else
            o_Pending <= (o_Pending & ~clr_mask) | set_mask;
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter with a negedge-committing register bank model.
module tb_writeback_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       stall = 1'b0;
    logic       alu_valid = 1'b0, mem_valid = 1'b0, issue_valid = 1'b0;
    logic [2:0] alu_addr = '0, mem_addr = '0, issue_addr = '0;
    logic [7:0] alu_data = '0, mem_data = '0;
    logic       alu_ready, mem_ready, write_back;
    logic [2:0] addr_reg_dest;
    logic [7:0] write_data;
    logic [7:0] pending;
    logic [7:0] bank [8];

    int checks = 0;
    int failures = 0;

    writeback_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
        .i_CLK(clk), .i_RST(rst), .i_Stall(stall),
        .i_AluValid(alu_valid), .i_AluAddr(alu_addr), .i_AluData(alu_data), .o_AluReady(alu_ready),
        .i_MemValid(mem_valid), .i_MemAddr(mem_addr), .i_MemData(mem_data), .o_MemReady(mem_ready),
        .i_IssueValid(issue_valid), .i_IssueAddr(issue_addr),
        .o_WriteBack(write_back), .o_AddrRegDest(addr_reg_dest), .o_WriteData(write_data),
        .o_Pending(pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (!rst && write_back) bank[addr_reg_dest] <= write_data;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        alu_valid = 1'b0; mem_valid = 1'b0; issue_valid = 1'b0; stall = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (write_back !== 1'b0 || pending !== 8'h00 || addr_reg_dest !== 3'd0 || write_data !== 8'h00) begin
            failures++;
            $display("FAIL reset_state: wb=%b pend=%h addr=%0d data=%h, want 0/00/0/00",
                     write_back, pending, addr_reg_dest, write_data);
        end
        apply_reset();
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 8'h5A;
        issue_valid = 1'b1; issue_addr = 3'd6;
        tick();
        alu_valid = 1'b0; issue_valid = 1'b0;
        checks++;
        if (write_back !== 1'b1 || pending !== 8'h40) begin
            failures++;
            $display("FAIL reset_pre: wb=%b pend=%h, want 1/40", write_back, pending);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (write_back !== 1'b0 || pending !== 8'h00) begin
            failures++;
            $display("FAIL reset_midwrite: wb=%b pend=%h, want 0/00", write_back, pending);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_alu_only;
        apply_reset();
        alu_valid = 1'b1; alu_addr = 3'd3; alu_data = 8'h5A;
        #1;
        checks++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin
            failures++;
            $display("FAIL alu_ready: alu=%b mem=%b, want 1/0", alu_ready, mem_ready);
        end
        tick();
        alu_valid = 1'b0;
        checks++;
        if (write_back !== 1'b1 || addr_reg_dest !== 3'd3 || write_data !== 8'h5A) begin
            failures++;
            $display("FAIL alu_write: wb=%b addr=%0d data=%h, want 1/3/5a", write_back, addr_reg_dest, write_data);
        end
        @(negedge clk); #1;
        checks++;
        if (bank[3] !== 8'h5A) begin
            failures++;
            $display("FAIL alu_bank: r3=%h, want 5a", bank[3]);
        end
        tick();
        checks++;
        if (write_back !== 1'b0 || addr_reg_dest !== 3'd3 || write_data !== 8'h5A) begin
            failures++;
            $display("FAIL alu_hold: wb=%b addr=%0d data=%h, want 0/3/5a", write_back, addr_reg_dest, write_data);
        end
    endtask

    task automatic test_back_to_back;
        logic [2:0] exp_addr;
        logic [7:0] exp_data;
        apply_reset();
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 8'h11;
        mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 8'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (mem_ready !== (i % 2 == 0) || alu_ready !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: alu=%b mem=%b, want mem=%b", i, alu_ready, mem_ready, i % 2 == 0);
            end
            exp_addr = (i % 2 == 0) ? 3'd2 : 3'd1;
            exp_data = (i % 2 == 0) ? mem_data : alu_data;
            tick();
            checks++;
            if (write_back !== 1'b1 || addr_reg_dest !== exp_addr || write_data !== exp_data) begin
                failures++;
                $display("FAIL rr_write[%0d]: wb=%b addr=%0d data=%h, want 1/%0d/%h",
                         i, write_back, addr_reg_dest, write_data, exp_addr, exp_data);
            end
            if (i % 2 == 0) mem_data = mem_data + 8'h01;
            else            alu_data = alu_data + 8'h01;
        end
        alu_valid = 1'b0; mem_valid = 1'b0;
        tick();
        checks++;
        if (write_back !== 1'b0) begin
            failures++;
            $display("FAIL rr_idle: wb=%b, want 0", write_back);
        end
    endtask

    task automatic test_stall;
        apply_reset();
        stall = 1'b1;
        alu_valid = 1'b1; alu_addr = 3'd1; alu_data = 8'h31;
        mem_valid = 1'b1; mem_addr = 3'd2; mem_data = 8'h32;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
                failures++;
                $display("FAIL stall_ready[%0d]: alu=%b mem=%b, want 0/0", i, alu_ready, mem_ready);
            end
            tick();
            checks++;
            if (write_back !== 1'b0) begin
                failures++;
                $display("FAIL stall_wb[%0d]: wb=%b, want 0", i, write_back);
            end
        end
        stall = 1'b0;
        #1;
        checks++;
        if (mem_ready !== 1'b1 || alu_ready !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: alu=%b mem=%b, want 0/1", alu_ready, mem_ready);
        end
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        checks++;
        if (write_back !== 1'b1 || addr_reg_dest !== 3'd2 || write_data !== 8'h32) begin
            failures++;
            $display("FAIL stall_write: wb=%b addr=%0d data=%h, want 1/2/32", write_back, addr_reg_dest, write_data);
        end
    endtask

    task automatic test_scoreboard;
        apply_reset();
        issue_valid = 1'b1; issue_addr = 3'd5;
        tick();
        issue_valid = 1'b0;
        checks++;
        if (pending !== 8'h20) begin
            failures++;
            $display("FAIL sb_set: pend=%h, want 20", pending);
        end
        // Issue again to an already pending register: no count, just stays set.
        issue_valid = 1'b1;
        mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 8'h55;
        tick();
        issue_valid = 1'b0; mem_valid = 1'b0;
        checks++;
        if (pending !== 8'h20 || write_back !== 1'b1) begin
            failures++;
            $display("FAIL sb_during_write: pend=%h wb=%b, want 20/1", pending, write_back);
        end
        tick();
        checks++;
        if (pending !== 8'h00) begin
            failures++;
            $display("FAIL sb_clear: pend=%h, want 00", pending);
        end
        issue_valid = 1'b1;
        tick();
        issue_valid = 1'b0;
        mem_valid = 1'b1; mem_data = 8'h56;
        tick();
        mem_valid = 1'b0;
        issue_valid = 1'b1; stall = 1'b1;
        tick();
        issue_valid = 1'b0; stall = 1'b0;
        checks++;
        if (pending !== 8'h20) begin
            failures++;
            $display("FAIL sb_set_wins: pend=%h, want 20", pending);
        end
        // Write to a non-pending register leaves its bit at 0.
        alu_valid = 1'b1; alu_addr = 3'd0; alu_data = 8'h01;
        tick();
        alu_valid = 1'b0;
        tick();
        checks++;
        if (pending !== 8'h20) begin
            failures++;
            $display("FAIL sb_nonpending: pend=%h, want 20", pending);
        end
    endtask

    task automatic test_same_reg;
        apply_reset();
        alu_valid = 1'b1; alu_addr = 3'd4; alu_data = 8'hAA;
        mem_valid = 1'b1; mem_addr = 3'd4; mem_data = 8'hBB;
        #1;
        if (mem_ready) begin
            tick();
            mem_valid = 1'b0;
        end
        tick();
        alu_valid = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (bank[4] !== 8'hAA) begin
            failures++;
            $display("FAIL same_reg: r4=%h, want aa", bank[4]);
        end
        tick();
        checks++;
        if (write_back !== 1'b0 || bank[4] !== 8'hAA) begin
            failures++;
            $display("FAIL same_reg_idle: wb=%b r4=%h, want 0/aa", write_back, bank[4]);
        end
    endtask

    initial begin
        foreach (bank[k]) bank[k] = 8'h00;
        test_reset();
        test_alu_only();
        test_back_to_back();
        test_stall();
        test_scoreboard();
        test_same_reg();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: sim time exceeded, want completion");
        $fatal(1, "timeout");
    end

endmodule
